// File: rtl/mem_access_ctrl.sv
// Load/store/fetch sequencer between the CPU datapath and a single-port memory.
// Each access runs IDLE -> REQ -> WAIT -> DONE, with an optional ack timeout that raises a sticky error.
module mem_access_ctrl #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 32,
  parameter int          PC_W    = 8,
  parameter int          TIMEOUT = 15,
  parameter logic [3:0]  OP_LDR  = 4'b1101,
  parameter logic [3:0]  OP_STR  = 4'b1110
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [3:0]        op_code,
  input  logic [DATA_W-1:0] SR1,
  input  logic [DATA_W-1:0] SR2,
  input  logic [DATA_W-1:0] offset,
  input  logic [PC_W-1:0]   pc,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] data_reg,
  output logic              ldr_valid,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              str_done,
  output logic              busy,
  output logic              error
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {K_FETCH, K_LDR, K_STR} kind_t;

  localparam int SUM_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            r_state, w_next;
  kind_t             r_kind, w_kind;
  logic [CNT_W-1:0]  r_cnt;
  logic [SUM_W-1:0]  w_sum;
  logic [ADDR_W-1:0] w_ls_addr;
  logic [ADDR_W-1:0] w_pc_addr;
  logic              w_expire;

  // Base is zero-extended, offset sign-extended; the sum wraps at ADDR_W.
  assign w_sum     = SUM_W'(SR1) + SUM_W'($signed(offset));
  assign w_ls_addr = w_sum[ADDR_W-1:0];
  assign w_pc_addr = ADDR_W'(pc);
  // r_cnt holds the number of ack-less WAIT cycles already seen.
  assign w_expire  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_comb begin
    w_kind = K_FETCH;
    if (op_code == OP_LDR)      w_kind = K_LDR;
    else if (op_code == OP_STR) w_kind = K_STR;
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_REQ;
      S_REQ:  w_next = S_WAIT;
      S_WAIT: begin
        if (mem_ack)       w_next = S_DONE;
        else if (w_expire) w_next = S_IDLE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req     = (r_state == S_REQ);
    busy        = (r_state == S_REQ) || (r_state == S_WAIT);
    ldr_valid   = (r_state == S_DONE) && (r_kind == K_LDR);
    instr_valid = (r_state == S_DONE) && (r_kind == K_FETCH);
    str_done    = (r_state == S_DONE) && (r_kind == K_STR);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_kind    <= K_FETCH;
      r_cnt     <= '0;
      mem_rw    <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      data_reg  <= '0;
      instr     <= '0;
      error     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_kind <= w_kind;
            error  <= 1'b0;
            case (w_kind)
              K_LDR: begin
                mem_addr <= w_ls_addr;
                mem_rw   <= 1'b1;
              end
              K_STR: begin
                mem_addr  <= w_ls_addr;
                mem_rw    <= 1'b0;
                mem_wdata <= SR2;
              end
              default: begin
                mem_addr <= w_pc_addr;
                mem_rw   <= 1'b1;
              end
            endcase
          end
        end
        S_REQ: r_cnt <= '0;
        S_WAIT: begin
          if (mem_ack) begin
            if (r_kind == K_LDR)   data_reg <= mem_rdata;
            if (r_kind == K_FETCH) instr    <= mem_rdata;
          end else if (w_expire) begin
            error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
